// File: rtl/linear_layer_ctrl_pkg.sv
// Shared control types and constants for the Linear_Layer dataflow region.
package linear_layer_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } dispatch_state_t;

  localparam int unsigned DEFAULT_MAX_INFLIGHT = 4;

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down counter. A simultaneous inc and dec cancel each other.
// A dec at zero leaves the count at zero and sets a sticky underflow flag.
module credit_counter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned MAX   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX);

  // Count update with saturation at both ends; underflow is held until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (count != MAX_CNT) count <= count + WIDTH'(1);
        end
        2'b01: begin
          if (count != '0) count <= count - WIDTH'(1);
          else             underflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pe_start_dispatcher.sv
// Pops start tokens from the start FIFO and drives the PE ap_ctrl_hs start
// handshake, limiting the number of started-but-not-done tasks.
module pe_start_dispatcher
  import linear_layer_ctrl_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT   = DEFAULT_MAX_INFLIGHT,
  parameter int unsigned CNT_WIDTH      = 3,
  parameter int unsigned TASK_CNT_WIDTH = 32
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      start_empty_n,
  output logic                      start_read,
  output logic                      pe_ap_start,
  input  logic                      pe_ap_ready,
  input  logic                      pe_ap_done,
  output logic [CNT_WIDTH-1:0]      inflight,
  output logic [TASK_CNT_WIDTH-1:0] task_count,
  output logic                      busy,
  output logic                      err_underflow
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_INFLIGHT);

  dispatch_state_t state;
  logic            accept;

  // Pop only when idle with credit, judged on the registered in-flight count;
  // gated by reset so no token is consumed while the region is held in reset
  always_comb begin
    start_read = ap_rst_n && (state == IDLE) && start_empty_n && (inflight < MAX_CNT);
    accept     = (state == ARMED) && pe_ap_ready;
  end

  // Start is decoded straight from the state register, so it is glitch-free
  // and drops asynchronously with reset
  always_comb begin
    pe_ap_start = (state == ARMED);
    busy        = (state != IDLE) || (inflight != '0);
  end

  // Handshake FSM and dispatched-task counter
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= IDLE;
      task_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_read) state <= ARMED;
        end
        ARMED: begin
          if (pe_ap_ready) begin
            state      <= IDLE;
            task_count <= task_count + TASK_CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  credit_counter #(
    .WIDTH (CNT_WIDTH),
    .MAX   (MAX_INFLIGHT)
  ) u_inflight (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .inc       (accept),
    .dec       (pe_ap_done),
    .count     (inflight),
    .underflow (err_underflow)
  );

endmodule

// File: tb/tb_pe_start_dispatcher.sv
// Self-checking bench for pe_start_dispatcher: expected pop/accept cycles are
// queued as stimulus is driven and matched when the DUT shows them.
module tb_pe_start_dispatcher;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        start_empty_n = 1'b0;
  logic        start_read;
  logic        pe_ap_start;
  logic        pe_ap_ready = 1'b0;
  logic        pe_ap_done = 1'b0;
  logic [2:0]  inflight;
  logic [31:0] task_count;
  logic        busy;
  logic        err_underflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pop_q[$];
  int acc_q[$];

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  pe_start_dispatcher #(
    .MAX_INFLIGHT   (4),
    .CNT_WIDTH      (3),
    .TASK_CNT_WIDTH (32)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .start_empty_n (start_empty_n),
    .start_read    (start_read),
    .pe_ap_start   (pe_ap_start),
    .pe_ap_ready   (pe_ap_ready),
    .pe_ap_done    (pe_ap_done),
    .inflight      (inflight),
    .task_count    (task_count),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Scoreboard: every pop and every accepted start must match a queued cycle
  always @(negedge ap_clk) begin
    if (start_read === 1'b1) begin
      if (pop_q.size() == 0) check("pop_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      else                   check("pop_cycle", 32'(cyc), 32'(pop_q.pop_front()));
    end
    if (pe_ap_start === 1'b1 && pe_ap_ready === 1'b1) begin
      if (acc_q.size() == 0) check("acc_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      else                   check("acc_cycle", 32'(cyc), 32'(acc_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int d;

    // Reset values, with a token offered while reset is held
    start_empty_n = 1'b1;
    repeat (2) tick();
    check("rst_start_read", start_read, 0);
    check("rst_pe_start", pe_ap_start, 0);
    check("rst_inflight", inflight, 0);
    check("rst_task_count", task_count, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_underflow, 0);
    start_empty_n = 1'b0;
    ap_rst_n = 1'b1;
    tick();

    // Single token, ready tied high
    pe_ap_ready = 1'b1;
    c = cyc;
    pop_q.push_back(c);
    acc_q.push_back(c + 1);
    start_empty_n = 1'b1;
    tick();
    start_empty_n = 1'b0;
    check("single_start", pe_ap_start, 1);
    tick();
    check("single_start_low", pe_ap_start, 0);
    check("single_inflight", inflight, 1);
    check("single_task_count", task_count, 1);
    check("single_busy", busy, 1);
    pe_ap_done = 1'b1;
    tick();
    pe_ap_done = 1'b0;
    check("single_done_inflight", inflight, 0);
    check("single_done_busy", busy, 0);

    // Credit exhaustion: four pops two cycles apart, then blocked
    c = cyc;
    for (int k = 0; k < 4; k++) begin
      pop_q.push_back(c + 2 * k);
      acc_q.push_back(c + 2 * k + 1);
    end
    start_empty_n = 1'b1;
    repeat (8) tick();
    check("cred_inflight_full", inflight, 4);
    repeat (4) tick();
    check("cred_blocked", start_read, 0);
    check("cred_task_count", task_count, 5);
    d = cyc;
    pop_q.push_back(d + 1);
    acc_q.push_back(d + 2);
    pe_ap_done = 1'b1;
    check("cred_no_same_cycle", start_read, 0);
    tick();
    pe_ap_done = 1'b0;
    check("cred_dec", inflight, 3);
    tick();
    start_empty_n = 1'b0;
    tick();
    check("cred_refill", inflight, 4);
    check("cred_task_count2", task_count, 6);
    pe_ap_done = 1'b1;
    repeat (4) tick();
    pe_ap_done = 1'b0;
    check("drain_inflight", inflight, 0);
    check("drain_err", err_underflow, 0);

    // Ready stall: start held for 10 cycles, no further pops
    pe_ap_ready = 1'b0;
    c = cyc;
    pop_q.push_back(c);
    start_empty_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall_start_held", pe_ap_start, 1);
      check("stall_task_count", task_count, 6);
      tick();
    end
    acc_q.push_back(cyc);
    pe_ap_ready = 1'b1;
    start_empty_n = 1'b0;
    tick();
    check("stall_released", pe_ap_start, 0);
    check("stall_task_count2", task_count, 7);
    check("stall_inflight", inflight, 1);

    // Bring in-flight to 2, then accept and done in the same cycle
    c = cyc;
    pop_q.push_back(c);
    acc_q.push_back(c + 1);
    start_empty_n = 1'b1;
    tick();
    start_empty_n = 1'b0;
    tick();
    check("simul_pre_inflight", inflight, 2);
    c = cyc;
    pop_q.push_back(c);
    acc_q.push_back(c + 1);
    start_empty_n = 1'b1;
    tick();
    start_empty_n = 1'b0;
    pe_ap_done = 1'b1;
    tick();
    pe_ap_done = 1'b0;
    check("simul_inflight", inflight, 2);
    check("simul_task_count", task_count, 9);
    pe_ap_done = 1'b1;
    repeat (2) tick();
    pe_ap_done = 1'b0;
    check("simul_drain", inflight, 0);

    // Underflow: done with nothing in flight, flag is sticky
    pe_ap_done = 1'b1;
    tick();
    pe_ap_done = 1'b0;
    check("uflow_flag", err_underflow, 1);
    check("uflow_inflight", inflight, 0);
    repeat (3) tick();
    check("uflow_sticky", err_underflow, 1);

    // Reset while ARMED: start drops at once, next pop on the first clock
    pe_ap_ready = 1'b0;
    c = cyc;
    pop_q.push_back(c);
    start_empty_n = 1'b1;
    tick();
    check("rarm_start", pe_ap_start, 1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("rarm_start_drop", pe_ap_start, 0);
    check("rarm_start_read", start_read, 0);
    check("rarm_task_count", task_count, 0);
    check("rarm_err", err_underflow, 0);
    check("rarm_busy", busy, 0);
    check("rarm_inflight", inflight, 0);
    tick();
    ap_rst_n = 1'b1;
    pe_ap_ready = 1'b1;
    c = cyc;
    pop_q.push_back(c);
    acc_q.push_back(c + 1);
    #1;
    check("rarm_pop_now", start_read, 1);
    tick();
    start_empty_n = 1'b0;
    tick();
    check("rarm_task_count2", task_count, 1);
    check("rarm_inflight2", inflight, 1);
    repeat (2) tick();

    check("pop_q_left", 32'(pop_q.size()), 0);
    check("acc_q_left", 32'(acc_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
